// File: rtl/qkt_bridge_feeder.sv
// ---------------------------------------------------------------------------
// qkt_bridge_feeder
//
// Purpose:
//   Accepts K-tiles (packed W slices plus an n operand) from an upstream
//   source one at a time. Each tile is held stable while the attention-head
//   core processes it. The feeder sequences the core's reset, enable,
//   accumulator-clear and output-valid controls. A block is a run of tiles
//   ending in a tile flagged s_last, or the NUM_TILES-th tile, whichever
//   comes first. Completed blocks are counted.
//
// Optional feature (macro QKT_FEEDER_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in WAIT_SYS/WAIT_ACC. After
//   TIMEOUT_CYC cycles in one of those states it flags proto_err and abandons
//   the block, with no block_done pulse. When undefined, the waits are
//   unbounded.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   s_valid/s_ready - upstream tile handshake
//   s_w_data        - NUM_SLICES*DATA_W packed W slices, slice 0 in LSBs
//   s_n_data        - N_W-bit n operand
//   s_last          - tile closes its block
//   w_out, n_out    - held tile operands to the core
//   en_out          - core compute enable
//   core_rst_n_out  - active-low core reset; low in IDLE and ISSUE
//   reset_acc_out   - accumulator clear, on the first tile of a block
//   out_valid_out   - accumulator output-valid gate
//   sys_finish_in   - core finished current tile (pulse)
//   acc_done_in     - block accumulation complete (pulse)
//   block_done      - one-cycle pulse per completed block
//   block_cnt       - completed block count, wraps at 16 bits
//   proto_err       - sticky protocol / timeout error
// ---------------------------------------------------------------------------
module qkt_bridge_feeder #(
    parameter int DATA_W      = 16,
    parameter int NUM_SLICES  = 4,
    parameter int N_W         = 64,
    parameter int NUM_TILES   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_SLICES*DATA_W-1:0] s_w_data,
    input  logic [N_W-1:0]               s_n_data,
    input  logic                         s_last,
    output logic [NUM_SLICES*DATA_W-1:0] w_out,
    output logic [N_W-1:0]               n_out,
    output logic                         en_out,
    output logic                         core_rst_n_out,
    output logic                         reset_acc_out,
    output logic                         out_valid_out,
    input  logic                         sys_finish_in,
    input  logic                         acc_done_in,
    output logic                         block_done,
    output logic [15:0]                  block_cnt,
    output logic                         proto_err
);

    localparam int W_W   = NUM_SLICES * DATA_W;
    localparam int IDX_W = $clog2(NUM_TILES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_SYS,
        WAIT_ACC
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] tile_idx_q;
    logic [W_W-1:0]   w_hold_q;
    logic [N_W-1:0]   n_hold_q;
    logic             last_hold_q;
    logic [15:0]      cnt_q;
    logic             err_q;
    logic             done_q;

    logic             tile_is_last;
    logic             accept;
    logic             complete;
    logic             advance;
    logic             err_set;
    logic             timeout;

    // The NUM_TILES-th tile closes the block even without s_last.
    assign tile_is_last = last_hold_q || (tile_idx_q == LAST_IDX);
    assign accept       = (state_q == IDLE) && s_valid;

`ifdef QKT_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            waiting;
    logic            wd_hit;

    assign waiting = (state_q == WAIT_SYS) || (state_q == WAIT_ACC);
    // wd_q counts completed cycles in the current wait state. The hit fires
    // on the TIMEOUT_CYC-th cycle in that state.
    assign wd_hit  = waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (!waiting || (state_d != state_q)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        s_ready        = 1'b0;
        en_out         = 1'b0;
        core_rst_n_out = 1'b0;
        reset_acc_out  = 1'b0;
        out_valid_out  = 1'b0;
        complete       = 1'b0;
        advance        = 1'b0;
        err_set        = 1'b0;
        timeout        = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                reset_acc_out = (tile_idx_q == '0);
                state_d       = WAIT_SYS;
            end
            WAIT_SYS: begin
                en_out         = 1'b1;
                core_rst_n_out = 1'b1;
                if (sys_finish_in) begin
                    if (tile_is_last) begin
                        // Forced close without s_last is an upstream error.
                        err_set = !last_hold_q;
                        if (acc_done_in) begin
                            complete = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = WAIT_ACC;
                        end
                    end else begin
                        advance = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_ACC: begin
                core_rst_n_out = 1'b1;
                out_valid_out  = 1'b1;
                if (acc_done_in) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stray completion strobes are dropped but remembered as errors.
        if (sys_finish_in && (state_q != WAIT_SYS)) begin
            err_set = 1'b1;
        end
        if (acc_done_in && (state_q != WAIT_SYS) && (state_q != WAIT_ACC)) begin
            err_set = 1'b1;
        end

`ifdef QKT_FEEDER_TIMEOUT_EN
        // A normal exit on the final cycle wins over the timeout.
        if (wd_hit && (state_d == state_q)) begin
            timeout = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tile_idx_q  <= '0;
            w_hold_q    <= '0;
            n_hold_q    <= '0;
            last_hold_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= complete;
            if (accept) begin
                w_hold_q    <= s_w_data;
                n_hold_q    <= s_n_data;
                last_hold_q <= s_last;
            end
            if (complete) begin
                cnt_q      <= cnt_q + 16'd1;
                tile_idx_q <= '0;
            end else if (timeout) begin
                tile_idx_q <= '0;
            end else if (advance) begin
                tile_idx_q <= tile_idx_q + IDX_W'(1);
            end
            if (err_set || timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign w_out      = w_hold_q;
    assign n_out      = n_hold_q;
    assign block_cnt  = cnt_q;
    assign block_done = done_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_qkt_bridge_feeder.sv
// ---------------------------------------------------------------------------
// tb_qkt_bridge_feeder
//
// Self-checking bench for qkt_bridge_feeder. A table of tile records drives
// the main block sequences. Hand-written sequences cover stray strobes,
// reset mid-block, the watchdog (or its absence) and block counter wrap.
// Expected operands and accumulator-clear values are queued when a tile is
// driven. They are popped and compared when the DUT shows its ISSUE cycle.
// ---------------------------------------------------------------------------
module tb_qkt_bridge_feeder;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  s_w_data;
    logic [63:0]  s_n_data;
    logic         s_last;
    logic [63:0]  w_out;
    logic [63:0]  n_out;
    logic         en_out;
    logic         core_rst_n_out;
    logic         reset_acc_out;
    logic         out_valid_out;
    logic         sys_finish_in;
    logic         acc_done_in;
    logic         block_done;
    logic [15:0]  block_cnt;
    logic         proto_err;

    qkt_bridge_feeder #(
        .DATA_W      (16),
        .NUM_SLICES  (4),
        .N_W         (64),
        .NUM_TILES   (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_w_data       (s_w_data),
        .s_n_data       (s_n_data),
        .s_last         (s_last),
        .w_out          (w_out),
        .n_out          (n_out),
        .en_out         (en_out),
        .core_rst_n_out (core_rst_n_out),
        .reset_acc_out  (reset_acc_out),
        .out_valid_out  (out_valid_out),
        .sys_finish_in  (sys_finish_in),
        .acc_done_in    (acc_done_in),
        .block_done     (block_done),
        .block_cnt      (block_cnt),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] w;
        logic [63:0] n;
        logic        last;
        int          fin;       // WAIT_SYS cycles before sys_finish_in
        logic        acc_same;  // acc_done_in together with sys_finish_in
        logic        hold_acc;  // leave the block parked in WAIT_ACC
        logic        exp_racc;
        logic        exp_last;
        logic        exp_err;
    } tile_vec_t;

    typedef struct {
        logic [63:0] w;
        logic [63:0] n;
        logic        racc;
    } sb_t;

    sb_t         sb_q[$];
    int          checks;
    int          errors;
    logic [15:0] exp_cnt;
    int          exp_dones;
    int          seen_dones;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ISSUE is the only state with s_ready, en_out and core_rst_n_out all low.
    always @(negedge clk) begin
        if (!rst && !s_ready && !en_out && !core_rst_n_out) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue: got issue expected none");
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_w_out", w_out, e.w);
                chk("sb_n_out", n_out, e.n);
                chk("sb_reset_acc", {63'd0, reset_acc_out}, {63'd0, e.racc});
            end
        end
    end

    always @(negedge clk) begin
        if (block_done) seen_dones++;
    end

    task automatic do_reset();
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        sys_finish_in = 1'b0;
        acc_done_in   = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 16'd0;
        sb_q.delete();
    endtask

    task automatic issue_only(input tile_vec_t v);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_idle", s_ready, 1);
        sb_q.push_back('{w: v.w, n: v.n, racc: v.exp_racc});
        s_valid  = 1'b1;
        s_w_data = v.w;
        s_n_data = v.n;
        s_last   = v.last;
        @(negedge clk);
        // Scramble inputs to confirm the outputs come from the hold registers.
        s_valid  = 1'b0;
        s_w_data = {$urandom(), $urandom()};
        s_n_data = {$urandom(), $urandom()};
        s_last   = 1'($urandom_range(0, 1));
        chk("issue_s_ready", s_ready, 0);
        @(negedge clk);
        chk("en_latency", en_out, 1);
        chk("core_rst_n_run", core_rst_n_out, 1);
    endtask

    task automatic run_tile(input tile_vec_t v);
        issue_only(v);
        repeat (v.fin - 1) @(negedge clk);
        chk("w_stable", w_out, v.w);
        chk("n_stable", n_out, v.n);
        sys_finish_in = 1'b1;
        acc_done_in   = v.acc_same;
        @(negedge clk);
        sys_finish_in = 1'b0;
        acc_done_in   = 1'b0;
        chk("proto_err", proto_err, v.exp_err);
        if (!v.exp_last) begin
            chk("nonlast_idle", s_ready, 1);
            chk("nonlast_no_done", block_done, 0);
        end else if (v.acc_same) begin
            chk("skip_acc_done", block_done, 1);
            chk("skip_acc_no_ov", out_valid_out, 0);
            chk("skip_acc_idle", s_ready, 1);
            exp_cnt++;
            exp_dones++;
            chk("block_cnt", block_cnt, exp_cnt);
        end else begin
            chk("wait_acc_ov", out_valid_out, 1);
            chk("wait_acc_en", en_out, 0);
            chk("wait_acc_no_done", block_done, 0);
            if (!v.hold_acc) begin
                repeat (3) @(negedge clk);
                chk("wait_acc_ov_hold", out_valid_out, 1);
                acc_done_in = 1'b1;
                @(negedge clk);
                acc_done_in = 1'b0;
                chk("acc_block_done", block_done, 1);
                exp_cnt++;
                exp_dones++;
                chk("block_cnt", block_cnt, exp_cnt);
                @(negedge clk);
                chk("block_done_pulse", block_done, 0);
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_en", en_out, 0);
        chk("rst_core_rst_n", core_rst_n_out, 0);
        chk("rst_reset_acc", reset_acc_out, 0);
        chk("rst_out_valid", out_valid_out, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_w_out", w_out, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_block_cnt", block_cnt, 0);
        chk("rst_proto_err", proto_err, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        tile_vec_t vecs[7];
        tile_vec_t t;
        int n;

        vecs[0] = '{w: 64'h1111_2222_3333_4444, n: 64'hA5A5_A5A5_0000_0001, last: 1'b0, fin: 10,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b1, exp_last: 1'b0, exp_err: 1'b0};
        vecs[1] = '{w: 64'h5555_6666_7777_8888, n: 64'h0123_4567_89AB_CDEF, last: 1'b1, fin: 10,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b0, exp_last: 1'b1, exp_err: 1'b0};
        vecs[2] = '{w: 64'hDEAD_BEEF_CAFE_F00D, n: 64'hFFFF_FFFF_FFFF_FFFF, last: 1'b1, fin: 3,
                    acc_same: 1'b1, hold_acc: 1'b0, exp_racc: 1'b1, exp_last: 1'b1, exp_err: 1'b0};
        vecs[3] = '{w: 64'h0000_0000_0000_0001, n: 64'h8000_0000_0000_0000, last: 1'b0, fin: 2,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b1, exp_last: 1'b0, exp_err: 1'b0};
        vecs[4] = '{w: 64'hFFFF_0000_FFFF_0000, n: 64'h0000_0000_0000_0042, last: 1'b0, fin: 5,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b0, exp_last: 1'b0, exp_err: 1'b0};
        vecs[5] = '{w: 64'h7FFF_8000_7FFF_8000, n: 64'h1357_9BDF_2468_ACE0, last: 1'b0, fin: 1,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b0, exp_last: 1'b0, exp_err: 1'b0};
        vecs[6] = '{w: 64'h0F0F_F0F0_1234_5678, n: 64'h0000_FFFF_0000_FFFF, last: 1'b0, fin: 4,
                    acc_same: 1'b0, hold_acc: 1'b0, exp_racc: 1'b0, exp_last: 1'b1, exp_err: 1'b1};

        checks     = 0;
        errors     = 0;
        exp_dones  = 0;
        seen_dones = 0;
        s_w_data   = '0;
        s_n_data   = '0;
        do_reset();
        chk_reset_outputs();

        // Two-tile block, single-tile block with merged strobes, and a
        // four-tile block closed by the tile limit.
        for (int i = 0; i < 7; i++) begin
            run_tile(vecs[i]);
        end

        // Stray sys_finish_in in IDLE.
        do_reset();
        chk("err_cleared", proto_err, 0);
        sys_finish_in = 1'b1;
        @(negedge clk);
        sys_finish_in = 1'b0;
        chk("stray_fin_err", proto_err, 1);
        chk("stray_fin_idle", s_ready, 1);

        // Stray acc_done_in in IDLE.
        do_reset();
        acc_done_in = 1'b1;
        @(negedge clk);
        acc_done_in = 1'b0;
        chk("stray_acc_err", proto_err, 1);
        chk("stray_acc_no_done", block_done, 0);
        chk("stray_acc_cnt", block_cnt, 0);

        // Reset while parked in WAIT_ACC discards the partial block.
        do_reset();
        run_tile(vecs[0]);
        t = vecs[1];
        t.hold_acc = 1'b1;
        run_tile(t);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_no_done", block_done, 0);
        rst = 1'b0;
        sb_q.delete();
        exp_cnt = 16'd0;
        chk_reset_outputs();
        t = vecs[2];
        run_tile(t);

        // Watchdog: no sys_finish_in after issue.
        t = vecs[2];
        t.exp_racc = 1'b1;
        issue_only(t);
`ifdef QKT_FEEDER_TIMEOUT_EN
        n = 0;
        while (en_out && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wd_cycles", n, 16);
        chk("wd_err", proto_err, 1);
        chk("wd_idle", s_ready, 1);
        chk("wd_no_done", block_done, 0);
        do_reset();
`else
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
        end
        chk("no_wd_en", en_out, 1);
        chk("no_wd_err", proto_err, 0);
        chk("no_wd_busy", s_ready, 0);
        sys_finish_in = 1'b1;
        acc_done_in   = 1'b1;
        @(negedge clk);
        sys_finish_in = 1'b0;
        acc_done_in   = 1'b0;
        chk("no_wd_done", block_done, 1);
        exp_cnt++;
        exp_dones++;
`endif

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        chk("preload_cnt", block_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        t = vecs[2];
        run_tile(t);
        chk("wrap_cnt_zero", block_cnt, 0);

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("done_pulses", seen_dones, exp_dones);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qkt_bridge_feeder.md
QKT_BRIDGE_FEEDER -- requirements
Module: qkt_bridge_feeder

Interface
REQ-001 Parameters, one per line: DATA_W, 16, width of one W0 slice; NUM_SLICES, 4, slices per tile; N_W, 64, width of n operand; NUM_TILES, 4, max K-tiles accumulated per output block; TIMEOUT_CYC, 1024, watchdog limit.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 s_valid  in  1  upstream tile valid.
REQ-005 s_ready  out  1  feeder can accept a tile.
REQ-006 s_w_data  in  NUM_SLICES*DATA_W  packed W slices, slice 0 in LSBs.
REQ-007 s_n_data  in  N_W  n operand.
REQ-008 s_last  in  1  tile is last K-tile of its block.
REQ-009 w_out  out  NUM_SLICES*DATA_W  held W slices to attention head.
REQ-010 n_out  out  N_W  held n operand.
REQ-011 en_out  out  1  core compute enable.
REQ-012 core_rst_n_out  out  1  active-low core reset pulse per tile.
REQ-013 reset_acc_out  out  1  clear accumulator, first tile of block.
REQ-014 out_valid_out  out  1  accumulator output-valid gate.
REQ-015 sys_finish_in  in  1  core finished current tile (pulse).
REQ-016 acc_done_in  in  1  accumulation of block complete (pulse).
REQ-017 block_done  out  1  one-cycle pulse per completed block.
REQ-018 block_cnt  out  16  completed blocks, wraps 0xFFFF->0.
REQ-019 proto_err  out  1  sticky protocol/timeout error.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_SYS, WAIT_ACC.
REQ-021 IDLE: s_ready=1; on s_valid, capture s_w_data/s_n_data/s_last into hold registers, go ISSUE; other states s_ready=0.
REQ-022 w_out/n_out SHALL equal hold registers and remain stable from ISSUE until leaving WAIT_SYS.
REQ-023 ISSUE (exactly one cycle): core_rst_n_out=0, en_out=0; reset_acc_out=1 iff tile_idx==0; next WAIT_SYS.
REQ-024 WAIT_SYS: en_out=1, core_rst_n_out=1; on sys_finish_in: if tile is last go WAIT_ACC, else tile_idx++ and go IDLE.
REQ-025 Tile is last when held s_last=1 or tile_idx==NUM_TILES-1; the latter without s_last sets proto_err.
REQ-026 WAIT_ACC: en_out=0, out_valid_out=1; on acc_done_in pulse block_done next cycle, block_cnt++, tile_idx=0, go IDLE.
REQ-027 sys_finish_in and acc_done_in same cycle in WAIT_SYS on last tile: skip WAIT_ACC, complete block as REQ-026.
REQ-028 sys_finish_in outside WAIT_SYS and acc_done_in outside WAIT_SYS/WAIT_ACC SHALL be ignored and set proto_err.
REQ-029 Latency: accept edge -> ISSUE next cycle -> en_out=1 second cycle after accept.
REQ-030 Minimum inter-tile gap: next accept no earlier than cycle after sys_finish_in.
REQ-031 tile_idx width clog2(NUM_TILES)+1; never exceeds NUM_TILES-1.

Reset
REQ-032 rst SHALL force IDLE, tile_idx=0, block_cnt=0, hold registers=0, proto_err=0, watchdog=0.
REQ-033 Output reset values: s_ready=1, en_out=0, core_rst_n_out=0, reset_acc_out=0, out_valid_out=0, block_done=0, w_out=0, n_out=0.
REQ-034 rst mid-block SHALL discard partial block with no block_done pulse; first post-reset tile gets reset_acc_out=1.

Configuration
REQ-035 Macro QKT_FEEDER_TIMEOUT_EN: when defined, watchdog counts cycles in WAIT_SYS/WAIT_ACC, clears on state change; at TIMEOUT_CYC sets proto_err, tile_idx=0, returns to IDLE without block_done; when undefined, no watchdog, states wait indefinitely.

Verification
REQ-036 Two tiles, s_last on second, sys_finish 10 cycles after each en -> reset_acc_out only for tile 0, one block_done, block_cnt=1.
REQ-037 NUM_TILES=4 tiles without s_last -> 4th treated last, proto_err=1, block_done after acc_done_in.
REQ-038 Single tile s_last=1, sys_finish_in and acc_done_in same cycle -> block_done next cycle, no WAIT_ACC cycle.
REQ-039 rst asserted in WAIT_ACC -> outputs at reset values, block_cnt=0, next tile reset_acc_out=1.
REQ-040 With QKT_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16, no sys_finish_in -> proto_err=1 after 16 WAIT_SYS cycles, FSM IDLE, s_ready=1.
REQ-041 block_cnt preloaded via 65536 blocks -> wraps to 0, block_done still pulses.
